// File: rtl/demux_stream_router.sv
// Buffered 1-to-4 stream router with valid/ready handshakes.
// Each output channel has a one-entry holding register and a delivered-word counter.
module demux_stream_router #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNTW  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_sel,
    input  logic [WIDTH-1:0]   in_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [4*CNTW-1:0]  deliv_cnt
);

    typedef enum logic {StEmpty, StFull} ch_state_e;

    logic [3:0] load;
    logic [3:0] pop;

    // A full channel can still accept when it is being drained on the same edge.
    assign in_ready = !out_valid[in_sel] || out_ready[in_sel];

    always_comb begin
        load         = '0;
        load[in_sel] = in_valid && in_ready;
    end

    assign pop = out_valid & out_ready;

    for (genvar i = 0; i < 4; i++) begin : g_ch
        ch_state_e        state_q, state_d;
        logic [WIDTH-1:0] data_q;
        logic [CNTW-1:0]  cnt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= StEmpty;
                data_q  <= '0;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                if (load[i]) begin
                    data_q <= in_data;
                end
                if (pop[i]) begin
                    cnt_q <= cnt_q + CNTW'(1);
                end
            end
        end

        always_comb begin
            state_d = state_q;
            unique case (state_q)
                StEmpty: begin
                    if (load[i]) begin
                        state_d = StFull;
                    end
                end
                StFull: begin
                    if (pop[i] && !load[i]) begin
                        state_d = StEmpty;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end

        assign out_valid[i]                = (state_q == StFull);
        assign out_data[i*WIDTH +: WIDTH]  = data_q;
        assign deliv_cnt[i*CNTW +: CNTW]   = cnt_q;
    end

endmodule

// File: tb/tb_demux_stream_router.sv
// Scoreboard bench for demux_stream_router: directed stimulus pushes expected words,
// a negedge monitor pops and compares whenever a channel is drained.
`timescale 1ns/1ps
module tb_demux_stream_router;

    localparam int W = 8;
    localparam int C = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_sel;
    logic [W-1:0]   in_data;
    logic [3:0]     out_valid;
    logic [3:0]     out_ready;
    logic [4*W-1:0] out_data;
    logic [4*C-1:0] deliv_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [1:0]   ch;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    demux_stream_router #(
        .WIDTH(W),
        .CNTW (C)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .deliv_cnt(deliv_cnt)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic int find_ch(input int ch);
        for (int k = 0; k < sb.size(); k++) begin
            if (int'(sb[k].ch) == ch) return k;
        end
        return -1;
    endfunction

    // Monitor: any held word must be expected; a drained word must be the oldest for its channel.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int i = 0; i < 4; i++) begin
                if (out_valid[i]) begin
                    int idx;
                    idx = find_ch(i);
                    if (idx < 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL ch%0d phantom: out_valid=1 with data %0h, expected no word",
                                 i, out_data[i*W +: W]);
                    end else if (out_ready[i]) begin
                        check($sformatf("ch%0d data", i), 64'(out_data[i*W +: W]),
                              64'(sb[idx].data));
                        sb.delete(idx);
                    end
                end
            end
        end
    end

    task automatic present(input logic [1:0] s, input logic [W-1:0] d, output logic rdy);
        exp_t e;
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        @(negedge clk);
        rdy = in_ready;
        if (rdy) begin
            e.ch   = s;
            e.data = d;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [1:0] s, input logic [W-1:0] d, output int waits);
        logic rdy;
        waits = 0;
        for (int t = 0; t < 64; t++) begin
            present(s, d, rdy);
            if (rdy) return;
            waits++;
        end
        n_tests++;
        n_fail++;
        $display("FAIL send ch%0d timeout: not accepted, required accept within 64 cycles", s);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int bound);
        for (int k = 0; k < bound; k++) begin
            if (out_valid == 4'b0000) break;
            cycles(1);
        end
        check("drain out_valid", 64'(out_valid), 64'(0));
        check("drain scoreboard", 64'(sb.size()), 64'(0));
    endtask

    task automatic check_cnt(input int e0, input int e1, input int e2, input int e3);
        check("deliv_cnt0", 64'(deliv_cnt[0*C +: C]), 64'(e0));
        check("deliv_cnt1", 64'(deliv_cnt[1*C +: C]), 64'(e1));
        check("deliv_cnt2", 64'(deliv_cnt[2*C +: C]), 64'(e2));
        check("deliv_cnt3", 64'(deliv_cnt[3*C +: C]), 64'(e3));
    endtask

    task automatic check_ready_all();
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #0.5;
            check($sformatf("in_ready after reset sel%0d", s), 64'(in_ready), 64'(1));
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] sweep_d [4];
        logic         rdy;
        int           w;
        int           waits;

        sweep_d   = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = '0;
        out_ready = 4'b0000;

        #2;
        check("reset out_valid", 64'(out_valid), 64'(0));
        check("reset out_data", 64'(out_data), 64'(0));
        check("reset deliv_cnt", 64'(deliv_cnt), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_ready_all();

        // Routing sweep: each lane holds its word for exactly one cycle.
        out_ready = 4'b1111;
        for (int s = 0; s < 4; s++) begin
            send(2'(s), sweep_d[s], w);
            check($sformatf("sweep out_valid after sel%0d", s), 64'(out_valid), 64'(1 << s));
        end
        cycles(1);
        check("sweep final out_valid", 64'(out_valid), 64'(0));
        check_cnt(1, 1, 1, 1);

        // Asynchronous reset with a word buffered in ch2.
        out_ready = 4'b0000;
        send(2'd2, 8'hA5, w);
        check("ch2 loaded", 64'(out_valid), 64'(4'b0100));
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", 64'(out_valid), 64'(0));
        check("midreset deliv_cnt", 64'(deliv_cnt), 64'(0));
        check("midreset out_data", 64'(out_data), 64'(0));
        sb.delete();
        cycles(1);
        rst_n = 1'b1;
        check_ready_all();
        cycles(1);

        // Back-pressure on ch1; ch3 keeps flowing; release drains and reloads with no bubble.
        out_ready = 4'b1101;
        send(2'd1, 8'h5A, w);
        present(2'd1, 8'h6B, rdy);
        check("stall in_ready ch1", 64'(rdy), 64'(0));
        present(2'd3, 8'h7C, rdy);
        check("ch3 accepted during stall", 64'(rdy), 64'(1));
        check("stall out_valid", 64'(out_valid), 64'(4'b1010));
        out_ready = 4'b1111;
        present(2'd1, 8'h6B, rdy);
        check("no bubble in_ready ch1", 64'(rdy), 64'(1));
        check("after release out_valid", 64'(out_valid), 64'(4'b0010));
        drain(5);
        check_cnt(0, 2, 0, 1);

        // Full throughput into ch0.
        out_ready = 4'b0001;
        waits = 0;
        for (int k = 0; k < 20; k++) begin
            send(2'd0, W'(k), w);
            waits += w;
        end
        check("throughput stall cycles", 64'(waits), 64'(0));
        drain(5);
        check_cnt(20, 2, 0, 1);

        // Counter wrap on ch3 from a fresh reset.
        #1;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        sb.delete();
        cycles(1);
        out_ready = 4'b1000;
        for (int k = 0; k < 257; k++) begin
            send(2'd3, W'(k), w);
        end
        drain(5);
        check_cnt(0, 0, 0, 1);

        // in_valid low: toggling select/data must load nothing.
        out_ready = 4'b0000;
        in_valid  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            in_sel  = 2'($urandom);
            in_data = W'($urandom);
            @(negedge clk);
            check("idle out_valid", 64'(out_valid), 64'(0));
            @(posedge clk);
            #1;
        end
        check_cnt(0, 0, 0, 1);
        check("final scoreboard empty", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_stream_router.md
Name: demux_stream_router

Overview:
- Buffered, handshaked 1-to-4 stream router. It takes the place of the combinational select-driven demux wherever the destinations can stall.
- It accepts one word per cycle on a valid/ready input with a 2-bit destination select. It steers the word into a one-entry holding register for that output channel.
- Each of the four output channels drains independently through its own valid/ready handshake.
- Per-channel delivered-word counters give visibility for debug and for the bench.

Parameters:
- WIDTH, 8: data word width in bits.
- CNTW, 8: width of each per-channel delivered-word counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream presents a word.
- in_ready  output  1  router can accept the word at in_sel this cycle.
- in_sel  input  2  destination channel 0..3; meaningful only when in_valid=1.
- in_data  input  WIDTH  input word.
- out_valid  output  4  bit i = channel i holds a word.
- out_ready  input  4  bit i = channel i consumer takes the word.
- out_data  output  4*WIDTH  lane i = out_data[i*WIDTH +: WIDTH].
- deliv_cnt  output  4*CNTW  lane i = number of words popped from channel i, modulo 2^CNTW.

Behaviour:
- Reset (rst_n=0, asynchronous, no clock needed): out_valid=4'b0000, all out_data lanes=0, all deliv_cnt lanes=0.
  - Any buffered words are discarded.
  - A reset asserted mid-transfer loses the word in flight. No partial state survives.
- Reset release: the first accept is possible on the first rising edge with rst_n=1.
- in_ready is combinational: in_ready = !out_valid[in_sel] || out_ready[in_sel].
  - It depends only on the selected channel and does not depend on in_valid.
  - Upstream must not make in_valid depend on in_ready.
- Accept: accept = in_valid && in_ready. On that edge, out_data lane in_sel <= in_data and out_valid[in_sel] <= 1.
- Pop of channel i: pop_i = out_valid[i] && out_ready[i]. On that edge, deliv_cnt lane i increments.
  - If channel i is not being loaded in the same cycle, out_valid[i] <= 0.
- Simultaneous pop and load on the same channel: the new word replaces the old one and out_valid stays 1. This sustains 1 word/cycle into a continuously ready channel.
- Latency: a word accepted at edge N is visible on out_valid/out_data immediately after edge N, so the earliest pop is at edge N+1.
- Full channel: with out_valid[in_sel]=1 and out_ready[in_sel]=0, in_ready=0. in_data/in_sel must be held stable by upstream until accepted.
  - Other channels keep draining meanwhile; they are not blocked.
- Per-edge limits:
  - Any subset of the four channels may pop on the same edge.
  - Only one channel (in_sel) may load per edge.
- in_valid=0: in_sel and in_data are ignored, and no channel is loaded.
- out_data lane i holds its last value after a pop. It is not cleared; it is valid only while out_valid[i]=1.
- deliv_cnt wraps from 2^CNTW-1 to 0 with no saturation and no flag.
- Counters count pops, not accepts.
- No data word is ever duplicated, dropped (outside reset) or reordered within a channel.
- Implementation:
  - Per-channel state is one valid flag plus one WIDTH data register.
  - There is no global FSM. Each channel is a 2-state machine: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY goes to FULL on a load.
  - FULL stays FULL on load-with-pop or on a stall.
  - FULL goes to EMPTY on a pop without a load.

Test Plan:
- Reset mid-stream: load ch2 with 8'hA5, assert rst_n=0 between edges -> out_valid=0000 and deliv_cnt=0 immediately, with no clock needed. After release, in_ready=1 for every in_sel.
- Single routing sweep, all out_ready=1: send 8'h11,8'h22,8'h33,8'h44 with in_sel=0,1,2,3 on consecutive cycles -> each lane shows its word for exactly one cycle after acceptance. Final deliv_cnt lanes are 1,1,1,1.
- Back-pressure: out_ready[1]=0, send 8'h5A to ch1, then 8'h6B to ch1 -> the first is accepted and in_ready drops to 0 for in_sel=1. Sending 8'h7C to ch3 in the same stall period is accepted and delivered. Raise out_ready[1] -> 8'h5A pops, and 8'h6B is accepted on that same edge with no bubble.
- Full throughput: out_ready[0]=1, 20 consecutive words 0..19 to ch0 -> in_ready stays 1 throughout. Words emerge in order one per cycle, and deliv_cnt lane 0 = 20.
- Counter wrap: deliver 257 words to ch3 -> deliv_cnt lane 3 = 1 with CNTW=8. Other lanes are unchanged.
- in_valid=0 with toggling in_sel/in_data for 10 cycles -> no out_valid bit rises and the counters are unchanged.
